// File: rtl/ts_sync_lock.sv
// rtl/ts_sync_lock.sv - transport-stream sync acquisition and packet-aligned forwarding
//
// Hunts for the 0x47 sync byte at a fixed packet pitch, confirms it over
// LOCK_COUNT packets, then forwards whole aligned packets with a regenerated
// mpeg_sync. Lock is dropped after UNLOCK_COUNT consecutive bad sync positions.
//
// Build option: define TS_SYNC_INV_EN to also accept 8'hB8 (inverted sync,
// energy-dispersal frame start) as a good sync byte.
//
// Ports:
//   mpeg_clk   in   1  byte clock, rising edge
//   mpeg_rst   in   1  asynchronous active-high reset
//   raw_data   in   8  raw TS byte
//   raw_valid  in   1  raw_data carries a byte this cycle
//   mpeg_data  out  8  aligned byte (registered, holds when no byte arrives)
//   mpeg_valid out  1  mpeg_data is a forwarded byte (only while locked)
//   mpeg_sync  out  1  forwarded byte is byte 0 of a packet
//   mpeg_err   out  1  forwarded byte 0 whose sync byte was wrong (flywheel)
//   locked     out  1  state machine is in LOCK
//   loss_cnt   out 16  saturating count of lock-loss events

module ts_sync_lock #(
    parameter int PKT_LEN      = 188,
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic       mpeg_clk,
    input  logic       mpeg_rst,
    input  logic [7:0] raw_data,
    input  logic       raw_valid,
    output logic [7:0] mpeg_data,
    output logic       mpeg_valid,
    output logic       mpeg_sync,
    output logic       mpeg_err,
    output logic       locked,
    output logic [15:0] loss_cnt
);

    localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  miss_q, miss_d;
    logic [15:0] loss_q, loss_d;

    logic [7:0]  data_q;
    logic        valid_q, valid_d;
    logic        sync_q, sync_d;
    logic        err_q, err_d;

    logic        sync_match;
    logic        at_sync;
    logic [7:0]  pos_next;

    always_comb begin
`ifdef TS_SYNC_INV_EN
        sync_match = (raw_data == 8'h47) || (raw_data == 8'hB8);
`else
        sync_match = (raw_data == 8'h47);
`endif
    end

    assign at_sync  = (pos_q == 8'd0);
    assign pos_next = (pos_q == LAST_POS) ? 8'd0 : pos_q + 8'd1;

    // State register and per-packet bookkeeping
    always_ff @(posedge mpeg_clk or posedge mpeg_rst) begin
        if (mpeg_rst) begin
            state_q <= S_HUNT;
            pos_q   <= 8'd0;
            good_q  <= 4'd0;
            miss_q  <= 4'd0;
            loss_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic; nothing moves on cycles without a byte
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        good_d  = good_q;
        miss_d  = miss_q;
        loss_d  = loss_q;
        if (raw_valid) begin
            case (state_q)
                S_HUNT: begin
                    // The matching byte itself is position 0, so the next byte is 1
                    if (sync_match) begin
                        state_d = S_VERIFY;
                        pos_d   = 8'd1;
                        good_d  = 4'd1;
                    end
                end
                S_VERIFY: begin
                    pos_d = pos_next;
                    if (at_sync) begin
                        if (sync_match) begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 == LOCK_N) begin
                                state_d = S_LOCK;
                                miss_d  = 4'd0;
                            end
                        end else begin
                            // The failing byte is not retried as a new candidate
                            state_d = S_HUNT;
                        end
                    end
                end
                S_LOCK: begin
                    pos_d = pos_next;
                    if (at_sync) begin
                        if (sync_match) begin
                            miss_d = 4'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                            if (miss_q + 4'd1 == UNLOCK_N) begin
                                state_d = S_HUNT;
                                if (loss_q != 16'hFFFF) begin
                                    loss_d = loss_q + 16'd1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase
        end
    end

    // Output decode: forwarding follows the state after this byte, so the
    // lock-completing sync is forwarded and the unlocking byte is not
    always_comb begin
        valid_d = raw_valid && (state_d == S_LOCK);
        sync_d  = valid_d && at_sync;
        err_d   = valid_d && at_sync && !sync_match;
    end

    always_ff @(posedge mpeg_clk or posedge mpeg_rst) begin
        if (mpeg_rst) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (raw_valid) begin
                data_q <= raw_data;
            end
            valid_q <= valid_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
        end
    end

    assign mpeg_data  = data_q;
    assign mpeg_valid = valid_q;
    assign mpeg_sync  = sync_q;
    assign mpeg_err   = err_q;
    assign locked     = (state_q == S_LOCK);
    assign loss_cnt   = loss_q;

endmodule
